aq_cp0_lpmd_seq: RTL
====================

AQ_CP0_LPMD_SEQ -- requirements
Module: aq_cp0_lpmd_seq

Interface
REQ-001 SHALL: reset cpurst_b, asynchronous, active-low; clock lpmd_clk.
REQ-002 SHALL: lpmd_clk  in  1  free-running sequencer clock, not gated by clk_en.
REQ-003 SHALL: cpurst_b  in  1  async active-low reset.
REQ-004 SHALL: wfi_req  in  1  WFI instruction at issue, level.
REQ-005 SHALL: pmu_sleep_req  in  1  external deep-sleep request, level.
REQ-006 SHALL: ifu_no_op, lsu_sync_ack, mmu_no_op  in  1 each  drain acknowledges.
REQ-007 SHALL: wake_evt  in  1  pending interrupt or debug wake-up.
REQ-008 SHALL: rtu_flush  in  1  pipeline flush.
REQ-009 SHALL: dbg_on  in  1  debug mode entered.
REQ-010 SHALL: wake_dly  in  4  clock-restart settle cycles, quasi-static.
REQ-011 SHALL: drain_req  out  1  request IFU/LSU/MMU quiesce.
REQ-012 SHALL: lpmd_b  out  2  low-power code to BIU: 11 run, 00 WFI, 01 deep sleep.
REQ-013 SHALL: clk_en  out  1  core clock enable.
REQ-014 SHALL: lpmd_stall  out  1  hold issue of the low-power instruction.
REQ-015 SHALL: lpmd_cmplt  out  1  one-cycle retire pulse.
REQ-016 SHALL: pmu_sleep_ack  out  1  deep sleep reached.
REQ-017 SHALL: seq_state  out  3  current state, debug visibility.

Function
REQ-018 SHALL: states and encodings are IDLE=000, DRAIN=001, SLEEP=010, WAKE=011, CMPLT=100; all other codes go to IDLE next cycle.
REQ-019 SHALL: in IDLE, wfi_req or pmu_sleep_req moves to DRAIN next cycle and latches mode_deep=pmu_sleep_req; when both are set, deep wins.
REQ-020 SHALL: drain_req=1 only in DRAIN.
REQ-021 SHALL: in DRAIN, ifu_no_op&lsu_sync_ack&mmu_no_op in the same cycle moves to SLEEP and registers lpmd_b=00 (WFI) or 01 (deep); acks in different cycles do not count.
REQ-022 SHALL: in SLEEP, clk_en=0, and pmu_sleep_ack = mode_deep.
REQ-023 SHALL: in SLEEP, wake_evt or dbg_on moves to WAKE, sets lpmd_b=11, and loads cnt=wake_dly.
REQ-024 SHALL: in WAKE, clk_en=1; cnt decrements each cycle; at cnt==0 moves to CMPLT, so WAKE lasts wake_dly+1 cycles.
REQ-025 SHALL: CMPLT lasts exactly one cycle, asserts lpmd_cmplt=1, then returns to IDLE.
REQ-026 SHALL: lpmd_stall = (IDLE & (wfi_req|pmu_sleep_req)) | DRAIN | SLEEP | WAKE; lpmd_stall=0 in CMPLT.
REQ-027 SHALL: rtu_flush or dbg_on in DRAIN returns to IDLE with lpmd_b unchanged (11) and no lpmd_cmplt; flush takes priority over a same-cycle drain ack.
REQ-028 SHALL: rtu_flush is ignored in SLEEP, WAKE and CMPLT.
REQ-029 SHALL: wake_evt asserted in DRAIN is held off until SLEEP is entered; no early exit.
REQ-030 SHALL: clk_en=1 in every state except SLEEP.
REQ-031 SHALL: all outputs are registered except lpmd_stall.

Reset
REQ-032 SHALL: reset asynchronously forces state IDLE, lpmd_b=11, cnt=0, mode_deep=0, clk_en=1, drain_req=0, lpmd_cmplt=0, pmu_sleep_ack=0, lpmd_stall=0.
REQ-033 SHALL: reset asserted mid-SLEEP immediately restores clk_en=1 and lpmd_b=11.

Configuration
REQ-034 SHALL: macro LPMD_DEEP_SLEEP_EN defined: pmu_sleep_req and the 01 code are functional as specified.
REQ-035 SHALL: LPMD_DEEP_SLEEP_EN undefined: pmu_sleep_req is ignored, mode_deep is tied 0, pmu_sleep_ack is tied 0, and lpmd_b never equals 01.

Verification
REQ-036 SHALL cover WFI path: wfi_req=1, acks at cycle 3, wake_dly=2, wake_evt at cycle 10 -> lpmd_b=00 during SLEEP, WAKE 3 cycles, one lpmd_cmplt, lpmd_b=11.
REQ-037 SHALL cover deep path: pmu_sleep_req and wfi_req both set -> lpmd_b=01, pmu_sleep_ack=1 in SLEEP (macro on); lpmd_b=00, ack=0 (macro off).
REQ-038 SHALL cover flush: rtu_flush in the same cycle as all three acks in DRAIN -> IDLE, lpmd_b stays 11, no lpmd_cmplt.
REQ-039 SHALL cover wake_dly=0: wake_evt in SLEEP -> WAKE 1 cycle, then CMPLT.
REQ-040 SHALL cover reset mid-SLEEP: cpurst_b low -> clk_en=1, lpmd_b=11, seq_state=000 without waiting for a clock edge.
REQ-041 SHALL cover split acks: ifu_no_op at cycle 2 and lsu_sync_ack/mmu_no_op at cycle 4 only -> remain in DRAIN until all three coincide.

Source files
------------

// File: rtl/aq_cp0_lpmd_seq_if.sv
// Core-side signal bundle for the low-power-mode sequencer.
// The sequencer uses the slave modport; the core/PMU side uses master.
interface aq_cp0_lpmd_seq_if;
    // Drain handshake: drain_req stays high for the whole of DRAIN. The three
    // acks are levels, and the drain counts as done only in a cycle where all
    // three are high together while drain_req is high. Acks seen in separate
    // cycles are never accumulated.
    logic       wfi_req;
    logic       pmu_sleep_req;
    logic       ifu_no_op;
    logic       lsu_sync_ack;
    logic       mmu_no_op;
    logic       wake_evt;
    logic       rtu_flush;
    logic       dbg_on;
    logic [3:0] wake_dly;

    logic       drain_req;
    logic [1:0] lpmd_b;
    logic       clk_en;
    logic       lpmd_stall;
    logic       lpmd_cmplt;
    logic       pmu_sleep_ack;
    logic [2:0] seq_state;

    modport slave (
        input  wfi_req, pmu_sleep_req, ifu_no_op, lsu_sync_ack, mmu_no_op,
        input  wake_evt, rtu_flush, dbg_on, wake_dly,
        output drain_req, lpmd_b, clk_en, lpmd_stall, lpmd_cmplt,
        output pmu_sleep_ack, seq_state
    );

    modport master (
        output wfi_req, pmu_sleep_req, ifu_no_op, lsu_sync_ack, mmu_no_op,
        output wake_evt, rtu_flush, dbg_on, wake_dly,
        input  drain_req, lpmd_b, clk_en, lpmd_stall, lpmd_cmplt,
        input  pmu_sleep_ack, seq_state
    );
endinterface

// File: rtl/aq_cp0_lpmd_seq.sv
// CP0 low-power-mode sequencer: drain, sleep, clock restart and retire of WFI/deep-sleep.
// Deep-sleep support (pmu_sleep_req, lpmd_b=01) is built only with LPMD_DEEP_SLEEP_EN.
module aq_cp0_lpmd_seq (
    input  logic             lpmd_clk,
    input  logic             cpurst_b,
    aq_cp0_lpmd_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_DRAIN = 3'b001,
        ST_SLEEP = 3'b010,
        ST_WAKE  = 3'b011,
        ST_CMPLT = 3'b100
    } state_t;

    state_t     state_q, state_d;
    logic       mode_deep_q, mode_deep_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] lpmd_b_q, lpmd_b_d;
    logic       clk_en_q, clk_en_d;
    logic       drain_req_q, drain_req_d;
    logic       cmplt_q, cmplt_d;
    logic       sleep_ack_q, sleep_ack_d;
    logic       stall;

    logic       deep_req;
    logic       all_ack;
    logic       drain_abort;
    logic       wake_go;

`ifdef LPMD_DEEP_SLEEP_EN
    assign deep_req = bus.pmu_sleep_req;
`else
    logic unused_pmu_sleep_req;
    assign unused_pmu_sleep_req = bus.pmu_sleep_req;
    assign deep_req             = 1'b0;
`endif

    assign all_ack     = bus.ifu_no_op & bus.lsu_sync_ack & bus.mmu_no_op;
    assign drain_abort = bus.rtu_flush | bus.dbg_on;
    assign wake_go     = bus.wake_evt | bus.dbg_on;

    always_ff @(posedge lpmd_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= ST_IDLE;
            mode_deep_q <= 1'b0;
            cnt_q       <= 4'd0;
            lpmd_b_q    <= 2'b11;
            clk_en_q    <= 1'b1;
            drain_req_q <= 1'b0;
            cmplt_q     <= 1'b0;
            sleep_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_deep_q <= mode_deep_d;
            cnt_q       <= cnt_d;
            lpmd_b_q    <= lpmd_b_d;
            clk_en_q    <= clk_en_d;
            drain_req_q <= drain_req_d;
            cmplt_q     <= cmplt_d;
            sleep_ack_q <= sleep_ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_deep_d = mode_deep_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.wfi_req | deep_req) begin
                    state_d     = ST_DRAIN;
                    mode_deep_d = deep_req;
                end
            end
            // Abort wins over a coincident drain completion; wake_evt is not looked at here.
            ST_DRAIN: begin
                if (drain_abort) begin
                    state_d = ST_IDLE;
                end else if (all_ack) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (wake_go) begin
                    state_d = ST_WAKE;
                    cnt_d   = bus.wake_dly;
                end
            end
            ST_WAKE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CMPLT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CMPLT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with state_q.
    always_comb begin
        clk_en_d    = (state_d != ST_SLEEP);
        drain_req_d = (state_d == ST_DRAIN);
        cmplt_d     = (state_d == ST_CMPLT);
        sleep_ack_d = (state_d == ST_SLEEP) & mode_deep_d;
        lpmd_b_d    = lpmd_b_q;
        if ((state_q == ST_DRAIN) && (state_d == ST_SLEEP)) begin
            lpmd_b_d = {1'b0, mode_deep_q};
        end else if (state_d != ST_SLEEP) begin
            lpmd_b_d = 2'b11;
        end
        stall = cpurst_b & (((state_q == ST_IDLE) & (bus.wfi_req | deep_req)) |
                            (state_q == ST_DRAIN) | (state_q == ST_SLEEP) |
                            (state_q == ST_WAKE));
    end

    assign bus.drain_req     = drain_req_q;
    assign bus.lpmd_b        = lpmd_b_q;
    assign bus.clk_en        = clk_en_q;
    assign bus.lpmd_stall    = stall;
    assign bus.lpmd_cmplt    = cmplt_q;
    assign bus.pmu_sleep_ack = sleep_ack_q;
    assign bus.seq_state     = state_q;

endmodule
